// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Generic pipeline register between two stages. Carries one
//            instruction word plus its PC per beat, strictly in order, with a
//            valid/ready handshake, flush-to-bubble, optional 2-entry skid
//            buffer and a saturating stall-cycle counter.
// Ports    : clk, rst (async, active-high)
//            flush, stall                 - pipeline control
//            in_valid/in_ready/in_code/in_pc      - producer side
//            out_valid/out_ready/out_code/out_pc  - consumer side
//            stall_cnt                    - cycles a live beat was not taken
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int          DATA_WIDTH = 32,
    parameter int          PC_WIDTH   = 32,
    parameter logic [31:0] NOP_CODE   = 32'h0000_0000,
    parameter bit          SKID_EN    = 1'b1,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_code,
    input  logic [PC_WIDTH-1:0]   in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_code,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam logic [DATA_WIDTH-1:0] c_NOP     = DATA_WIDTH'(NOP_CODE);
    localparam logic [PC_WIDTH-1:0]   c_PC_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_main_code, w_main_code_nxt;
    logic [PC_WIDTH-1:0]   r_main_pc,   w_main_pc_nxt;
    logic [DATA_WIDTH-1:0] r_skid_code, w_skid_code_nxt;
    logic [PC_WIDTH-1:0]   r_skid_pc,   w_skid_pc_nxt;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_consume;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_consume   = w_out_valid & out_ready & ~stall;
    assign w_accept    = in_valid & w_in_ready & ~flush;

    generate
        if (SKID_EN) begin : g_skid
            // Ready comes from registered state only; the skid entry absorbs
            // the beat that arrives while the consumer is backpressuring.
            assign w_in_ready = (r_state != S_TWO);
        end else begin : g_noskid
            assign w_in_ready = ~w_out_valid | w_consume;
        end
    endgenerate

    // Next-state and payload steering
    always_comb begin
        w_state_nxt     = r_state;
        w_main_code_nxt = r_main_code;
        w_main_pc_nxt   = r_main_pc;
        w_skid_code_nxt = r_skid_code;
        w_skid_pc_nxt   = r_skid_pc;
        if (flush) begin
            w_state_nxt     = S_EMPTY;
            w_main_code_nxt = c_NOP;
            w_main_pc_nxt   = c_PC_ZERO;
            w_skid_code_nxt = c_NOP;
            w_skid_pc_nxt   = c_PC_ZERO;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt     = S_ONE;
                        w_main_code_nxt = in_code;
                        w_main_pc_nxt   = in_pc;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_consume) begin
                        w_main_code_nxt = in_code;
                        w_main_pc_nxt   = in_pc;
                    end else if (w_accept && SKID_EN) begin
                        // Main is held; new beat parks behind it.
                        w_state_nxt     = S_TWO;
                        w_skid_code_nxt = in_code;
                        w_skid_pc_nxt   = in_pc;
                    end else if (w_consume) begin
                        w_state_nxt     = S_EMPTY;
                        w_main_code_nxt = c_NOP;
                        w_main_pc_nxt   = c_PC_ZERO;
                    end
                end
                S_TWO: begin
                    if (w_consume) begin
                        w_state_nxt     = S_ONE;
                        w_main_code_nxt = r_skid_code;
                        w_main_pc_nxt   = r_skid_pc;
                        w_skid_code_nxt = c_NOP;
                        w_skid_pc_nxt   = c_PC_ZERO;
                    end
                end
                default: begin
                    w_state_nxt     = S_EMPTY;
                    w_main_code_nxt = c_NOP;
                    w_main_pc_nxt   = c_PC_ZERO;
                    w_skid_code_nxt = c_NOP;
                    w_skid_pc_nxt   = c_PC_ZERO;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_main_code <= c_NOP;
            r_main_pc   <= c_PC_ZERO;
            r_skid_code <= c_NOP;
            r_skid_pc   <= c_PC_ZERO;
        end else begin
            r_state     <= w_state_nxt;
            r_main_code <= w_main_code_nxt;
            r_main_pc   <= w_main_pc_nxt;
            r_skid_code <= w_skid_code_nxt;
            r_skid_pc   <= w_skid_pc_nxt;
        end
    end

    // Counts cycles where a live beat sat unconsumed; sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_out_valid && !w_consume && !flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_code  = r_main_code;
    assign out_pc    = r_main_pc;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Self-checking bench for pipe_stage_reg. Drives one skid-enabled
//            and one skid-less instance with shared stimulus and compares both
//            against queue-based reference models of the held beats.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        flush, stall, in_valid, out_ready;
    logic [31:0] in_code, in_pc;

    logic        rdy1, ov1, rdy0, ov0;
    logic [31:0] code1, pc1, code0, pc0;
    logic [3:0]  cnt1, cnt0;

    int n_total = 0;
    int n_bad   = 0;

    // Reference models: queue of held beats {pc, code}, front = on output.
    logic [63:0] q1[$];
    logic [63:0] q0[$];
    int          m_cnt1, m_cnt0;
    logic        e1v, e1cons, e1rdy, e0v, e0cons, e0rdy;

    pipe_stage_reg #(.DATA_WIDTH(32), .PC_WIDTH(32), .NOP_CODE(c_NOP),
                     .SKID_EN(1'b1), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy1), .in_code(in_code), .in_pc(in_pc),
        .out_valid(ov1), .out_ready(out_ready), .out_code(code1), .out_pc(pc1),
        .stall_cnt(cnt1));

    pipe_stage_reg #(.DATA_WIDTH(32), .PC_WIDTH(32), .NOP_CODE(c_NOP),
                     .SKID_EN(1'b0), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .stall(stall),
        .in_valid(in_valid), .in_ready(rdy0), .in_code(in_code), .in_pc(in_pc),
        .out_valid(ov0), .out_ready(out_ready), .out_code(code0), .out_pc(pc0),
        .stall_cnt(cnt0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q1.delete();
        q0.delete();
        m_cnt1 = 0;
        m_cnt0 = 0;
    endtask

    // Compare every output of both instances against the models.
    task automatic check_all();
        logic [63:0] f1, f0;
        f1 = (q1.size() > 0) ? q1[0] : {32'h0, c_NOP};
        f0 = (q0.size() > 0) ? q0[0] : {32'h0, c_NOP};
        e1v    = (q1.size() > 0);
        e0v    = (q0.size() > 0);
        e1cons = e1v && out_ready && !stall;
        e0cons = e0v && out_ready && !stall;
        e1rdy  = (q1.size() < 2);
        e0rdy  = !e0v || e0cons;
        check_val("s1_in_ready",  {63'h0, rdy1}, {63'h0, e1rdy});
        check_val("s1_out_valid", {63'h0, ov1},  {63'h0, e1v});
        check_val("s1_out_code",  {32'h0, code1}, {32'h0, f1[31:0]});
        check_val("s1_out_pc",    {32'h0, pc1},   {32'h0, f1[63:32]});
        check_val("s1_stall_cnt", {60'h0, cnt1},  64'(m_cnt1));
        check_val("s0_in_ready",  {63'h0, rdy0}, {63'h0, e0rdy});
        check_val("s0_out_valid", {63'h0, ov0},  {63'h0, e0v});
        check_val("s0_out_code",  {32'h0, code0}, {32'h0, f0[31:0]});
        check_val("s0_out_pc",    {32'h0, pc0},   {32'h0, f0[63:32]});
        check_val("s0_stall_cnt", {60'h0, cnt0},  64'(m_cnt0));
    endtask

    // Advance the models across one clock edge using the current inputs.
    task automatic model_edge();
        logic acc1, acc0;
        if (rst) begin
            model_clear();
        end else begin
            acc1 = in_valid && e1rdy && !flush;
            acc0 = in_valid && e0rdy && !flush;
            if (e1v && !e1cons && !flush) m_cnt1 = (m_cnt1 == 15) ? 15 : m_cnt1 + 1;
            if (e0v && !e0cons && !flush) m_cnt0 = (m_cnt0 == 15) ? 15 : m_cnt0 + 1;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (e1cons) void'(q1.pop_front());
                if (e0cons) void'(q0.pop_front());
                if (acc1) q1.push_back({in_pc, in_code});
                if (acc0) q0.push_back({in_pc, in_code});
            end
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [31:0] pc,
                        input logic [31:0] code, input logic ordy,
                        input logic stl, input logic fl);
        @(negedge clk);
        rst       = r;
        in_valid  = iv;
        in_pc     = pc;
        in_code   = code;
        out_ready = ordy;
        stall     = stl;
        flush     = fl;
        if (r) model_clear();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 32'h0, 32'h0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
        out_ready = 1'b0; in_code = '0; in_pc = '0;
        model_clear();
        e1rdy = 1'b1; e0rdy = 1'b1; e1v = 1'b0; e0v = 1'b0; e1cons = 1'b0; e0cons = 1'b0;

        // Reset state, with a beat offered during reset that must be ignored
        step(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Streaming at full rate
        step(1'b0, 1'b1, 32'h00, 32'h2008_0001, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h04, 32'h2008_0002, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h08, 32'h2008_0003, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Backpressure: A then B with consumer stalled, then drain
        step(1'b0, 1'b1, 32'h20, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h24, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h28, 32'hCCCC_0003, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Flush with a beat presented in the flush cycle
        step(1'b0, 1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Skid-less ready follows out_ready; stall forces it low
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 32'h200 + 32'(4 * i), 32'h5000_0000 + 32'(i),
                 1'(i % 2), 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h300, 32'h5000_0100, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h304, 32'h5000_0101, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Asynchronous reset mid-cycle while the skid instance holds two beats
        step(1'b0, 1'b1, 32'h40, 32'h7000_0040, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h44, 32'h7000_0044, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0;
        #1;
        check_all();
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Stall counter saturation with the held beat stable
        step(1'b0, 1'b1, 32'h80, 32'h9000_0080, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 3) != 0),
                 $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 5) == 0),
                 1'($urandom_range(0, 19) == 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
